// File: rtl/xge_tx_arb_pkg.sv
// rtl/xge_tx_arb_pkg.sv - shared types and widths for the xge_mac transmit arbiter
package xge_tx_arb_pkg;

  localparam int DATA_W = 64;
  localparam int MOD_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic [DATA_W-1:0] data;
  } tx_word_t;

endpackage

// File: rtl/xge_rr_pick.sv
// rtl/xge_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module xge_rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!valid && req[j] && (j >= int'(ptr))) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// rtl/xge_tx_arbiter.sv - packet-level round-robin arbiter in front of the xge_mac pkt_tx port
module xge_tx_arbiter
  import xge_tx_arb_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int MAX_WORDS = 1200
) (
  input  logic                       clk_156m25,
  input  logic                       reset_156m25_n,
  input  logic [NUM_SRC-1:0]         src_val,
  input  logic [NUM_SRC-1:0]         src_sop,
  input  logic [NUM_SRC-1:0]         src_eop,
  input  logic [3*NUM_SRC-1:0]       src_mod,
  input  logic [64*NUM_SRC-1:0]      src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       pkt_tx_full,
  output logic                       pkt_tx_val,
  output logic                       pkt_tx_sop,
  output logic                       pkt_tx_eop,
  output logic [2:0]                 pkt_tx_mod,
  output logic [63:0]                pkt_tx_data,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       trunc_err,
  output logic                       proto_err,
  input  logic                       err_clr
);

  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  arb_state_t         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_nxt, grant_nxt, pick_idx, sel_idx;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_SRC-1:0] pick_gnt, stray;
  logic               pick_valid, fwd, trunc_set, proto_set;
  tx_word_t           sel, fwd_word;

  // Non-sop words offered while idle belong to no packet and are flushed.
  assign stray = src_val & ~src_sop;

  xge_rr_pick #(.N(NUM_SRC)) u_pick (
    .req   (src_val & src_sop),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign sel_idx = (state == IDLE) ? pick_idx : grant_id;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_idx == ID_W'(i)) begin
        sel.sop  = src_sop[i];
        sel.eop  = src_eop[i];
        sel.mod  = src_mod[3*i +: 3];
        sel.data = src_data[64*i +: 64];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    src_ready = '0;
    fwd       = 1'b0;
    fwd_word  = sel;
    trunc_set = 1'b0;
    proto_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pkt_tx_full) begin
          src_ready = pick_gnt | stray;
          proto_set = |stray;
          if (pick_valid) begin
            fwd          = 1'b1;
            fwd_word.sop = 1'b1;
            fwd_word.mod = sel.eop ? sel.mod : '0;
            grant_nxt    = pick_idx;
            cnt_nxt      = CNT_W'(1);
            rr_nxt       = (pick_idx == ID_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
            state_nxt    = sel.eop ? IDLE : XFER;
          end
        end
      end
      XFER: begin
        src_ready[grant_id] = !pkt_tx_full;
        if (src_val[grant_id] && !pkt_tx_full) begin
          fwd          = 1'b1;
          fwd_word.sop = 1'b0;
          cnt_nxt      = cnt + 1'b1;
          proto_set    = sel.sop;
          if (sel.eop) begin
            state_nxt = IDLE;
          end else begin
            fwd_word.mod = '0;
            // Last allowed word without eop: close the packet and discard the rest.
            if (cnt == CNT_W'(MAX_WORDS - 1)) begin
              fwd_word.eop = 1'b1;
              trunc_set    = 1'b1;
              state_nxt    = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        src_ready[grant_id] = 1'b1;
        if (src_val[grant_id] && src_eop[grant_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cnt         <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
      trunc_err   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      grant_id   <= grant_nxt;
      cnt        <= cnt_nxt;
      pkt_tx_val <= fwd;
      if (fwd) begin
        pkt_tx_sop  <= fwd_word.sop;
        pkt_tx_eop  <= fwd_word.eop;
        pkt_tx_mod  <= fwd_word.mod;
        pkt_tx_data <= fwd_word.data;
      end
      if (trunc_set)    trunc_err <= 1'b1;
      else if (err_clr) trunc_err <= 1'b0;
      if (proto_set)    proto_err <= 1'b1;
      else if (err_clr) proto_err <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// tb/tb_xge_tx_arbiter.sv - self-checking bench for xge_tx_arbiter with a per-source packet scoreboard
module tb_xge_tx_arbiter;
  import xge_tx_arb_pkg::*;

  localparam int NS = 2;
  localparam int MW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_val, src_sop, src_eop, src_ready;
  logic [3*NS-1:0] src_mod;
  logic [64*NS-1:0] src_data;
  logic            pkt_tx_full, pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]      pkt_tx_mod;
  logic [63:0]     pkt_tx_data;
  logic [0:0]      grant_id;
  logic            busy, trunc_err, proto_err, err_clr;

  always #5 clk = ~clk;

  xge_tx_arbiter #(.NUM_SRC(NS), .MAX_WORDS(MW)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .src_val        (src_val),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .src_mod        (src_mod),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .pkt_tx_full    (pkt_tx_full),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_data    (pkt_tx_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .trunc_err      (trunc_err),
    .proto_err      (proto_err),
    .err_clr        (err_clr)
  );

  int total = 0;
  int bad = 0;
  tx_word_t q0[$], q1[$], e0[$], e1[$], got[$];
  int got_gid[$], got_cyc[$];
  int cyc = 0, gap_pct = 0, full_pct = 0, full_lo = -1, full_hi = -1;
  int full_viol = 0, busy_hi = 0, pkt_no = 0;

  function automatic logic [75:0] outs();
    return {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
            grant_id, busy, trunc_err, proto_err, src_ready};
  endfunction

  // Source words go to q*, the words the MAC should see go to e*.
  function automatic void add_packet(int s, int len, logic [2:0] last_mod, int mid_sop_at);
    tx_word_t w, e;
    for (int i = 0; i < len; i++) begin
      w.sop  = (i == 0) || (i == mid_sop_at);
      w.eop  = (i == len - 1);
      w.mod  = w.eop ? last_mod : 3'($urandom_range(7));
      w.data = {4'(s), 12'(pkt_no), 16'(i), 32'($urandom)};
      e = w;
      e.sop = (i == 0);
      e.mod = w.eop ? last_mod : 3'd0;
      if (i == MW - 1 && !w.eop) begin
        e.eop = 1'b1;
        e.mod = 3'd0;
      end
      if (s == 0) q0.push_back(w); else q1.push_back(w);
      if (i < MW) begin
        if (s == 0) e0.push_back(e); else e1.push_back(e);
      end
    end
    pkt_no++;
  endfunction

  task automatic drive();
    tx_word_t w;
    logic have;
    for (int s = 0; s < NS; s++) begin
      have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have && int'($urandom_range(99)) >= gap_pct) begin
        w = (s == 0) ? q0[0] : q1[0];
        src_val[s] = 1'b1;
        src_sop[s] = w.sop;
        src_eop[s] = w.eop;
        src_mod[3*s +: 3] = w.mod;
        src_data[64*s +: 64] = w.data;
      end else begin
        src_val[s] = 1'b0;
      end
    end
    if (full_lo >= 0) pkt_tx_full = (cyc >= full_lo) && (cyc <= full_hi);
    else pkt_tx_full = (int'($urandom_range(99)) < full_pct);
  endtask

  task automatic cycle();
    logic [NS-1:0] xfer;
    tx_word_t w;
    @(negedge clk);
    if (pkt_tx_val) begin
      w = {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data};
      got.push_back(w);
      got_gid.push_back(int'(grant_id));
      got_cyc.push_back(cyc);
    end
    if (busy) busy_hi++;
    if (pkt_tx_full && src_ready != '0) full_viol++;
    xfer = src_val & src_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (xfer[0]) void'(q0.pop_front());
    if (xfer[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic run(input string name, input int max);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL %s drain: pending=%0d required=0", name, q0.size() + q1.size());
    end
    repeat (3) cycle();
  endtask

  task automatic check_stream(input string name);
    tx_word_t g, e;
    int s, cur, frag;
    cur = -1;
    frag = 0;
    for (int i = 0; i < got.size(); i++) begin
      g = got[i];
      s = int'(g.data[63:60]);
      if (s == 0 && e0.size() > 0) e = e0.pop_front();
      else if (s == 1 && e1.size() > 0) e = e1.pop_front();
      else e = ~g;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s word%0d: got=%h required=%h", name, i, g, e);
      end
      total++;
      if (got_gid[i] !== s) begin
        bad++;
        $display("FAIL %s grant_id%0d: got=%0d required=%0d", name, i, got_gid[i], s);
      end
      if (g.sop) cur = s;
      else if (cur != s) frag++;
      if (g.eop) cur = -1;
    end
    total++;
    if (frag != 0) begin
      bad++;
      $display("FAIL %s contiguity: interleaved=%0d required=0", name, frag);
    end
    total++;
    if (e0.size() + e1.size() != 0) begin
      bad++;
      $display("FAIL %s missing: words=%0d required=0", name, e0.size() + e1.size());
    end
    got.delete(); got_gid.delete(); got_cyc.delete(); e0.delete(); e1.delete();
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    got.delete(); got_gid.delete(); got_cyc.delete();
    src_val = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_all();
    pkt_tx_full = 1'b0;
    err_clr = 1'b0;
    gap_pct = 0;
    full_pct = 0;
    full_lo = -1;
    full_hi = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    full_viol = 0;
    busy_hi = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++;
    if (outs() !== '0) begin
      bad++;
      $display("FAIL reset_state: got=%h required=0", outs());
    end
    rst_n = 1'b1;
    add_packet(1, 4, 3'd5, -1);
    drive();
    cycle();
    cycle();
    total++;
    if (busy !== 1'b1 || pkt_tx_val !== 1'b1) begin
      bad++;
      $display("FAIL reset_midpkt_setup: busy=%b val=%b required=1 1", busy, pkt_tx_val);
    end
    #2;
    src_val = '0;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== '0) begin
      bad++;
      $display("FAIL reset_async: got=%h required=0", outs());
    end
    clear_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_packet(1, 1, 3'd6, -1);
    drive();
    cycle();
    total++;
    if (pkt_tx_val !== 1'b1 || {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data} !== e1[0]
        || grant_id !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_sop: val=%b word=%h gid=%0d required=1 %h 1",
               pkt_tx_val, {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}, grant_id, e1[0]);
    end
    cycle();
    total++;
    if (pkt_tx_val !== 1'b0) begin
      bad++;
      $display("FAIL reset_single_beat: val=%b required=0", pkt_tx_val);
    end
    clear_all();
  endtask

  task automatic test_round_robin();
    int order[$];
    int gaps;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add_packet(0, 4, 3'($urandom_range(7)), -1);
      add_packet(1, 4, 3'($urandom_range(7)), -1);
    end
    drive();
    run("rr", 200);
    gaps = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i].sop) order.push_back(int'(got[i].data[63:60]));
      if (i > 0 && (got_cyc[i] - got_cyc[i-1]) > (got[i].sop ? 2 : 1)) gaps++;
    end
    total++;
    if (order.size() != 8) begin
      bad++;
      $display("FAIL rr_count: got=%0d required=8", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      total++;
      if (order[k] != k % 2) begin
        bad++;
        $display("FAIL rr_order%0d: got=%0d required=%0d", k, order[k], k % 2);
      end
    end
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL rr_back_to_back: excess_gaps=%0d required=0", gaps);
    end
    check_stream("rr");
  endtask

  task automatic test_backpressure();
    int in_win;
    do_reset();
    add_packet(0, 4, 3'd2, -1);
    add_packet(1, 4, 3'd7, -1);
    add_packet(0, 3, 3'd4, -1);
    full_lo = 2;
    full_hi = 6;
    drive();
    run("bp", 200);
    in_win = 0;
    for (int i = 0; i < got_cyc.size(); i++)
      if (got_cyc[i] >= full_lo && got_cyc[i] <= full_hi) in_win++;
    total++;
    if (full_viol != 0) begin
      bad++;
      $display("FAIL bp_ready: ready_while_full=%0d required=0", full_viol);
    end
    total++;
    if (in_win > 1) begin
      bad++;
      $display("FAIL bp_inflight: words=%0d required<=1", in_win);
    end
    check_stream("bp");
  endtask

  task automatic test_truncation();
    do_reset();
    add_packet(0, 7, 3'd5, -1);
    add_packet(1, 3, 3'd2, -1);
    drive();
    run("trunc", 200);
    total++;
    if (got.size() != 7 || got[3].eop !== 1'b1 || got[3].mod !== 3'd0) begin
      bad++;
      $display("FAIL trunc_shape: words=%0d required=7 (4th eop/mod must be 1/0)", got.size());
    end
    total++;
    if (trunc_err !== 1'b1 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL trunc_flags: trunc=%b proto=%b required=1 0", trunc_err, proto_err);
    end
    check_stream("trunc");
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    total++;
    if (trunc_err !== 1'b0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL trunc_clear: trunc=%b proto=%b required=0 0", trunc_err, proto_err);
    end
  endtask

  task automatic test_proto_err();
    tx_word_t w;
    int sops;
    do_reset();
    w = '{sop: 1'b0, eop: 1'b0, mod: 3'd1, data: 64'h1000_0000_dead_beef};
    q1.push_back(w);
    err_clr = 1'b1;
    drive();
    cycle();
    err_clr = 1'b0;
    total++;
    if (proto_err !== 1'b1 || q1.size() != 0 || pkt_tx_val !== 1'b0) begin
      bad++;
      $display("FAIL proto_stray: err=%b left=%0d val=%b required=1 0 0", proto_err, q1.size(), pkt_tx_val);
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_clear: err=%b required=0", proto_err);
    end
    add_packet(0, 4, 3'd1, 2);
    drive();
    run("proto", 100);
    sops = 0;
    for (int i = 0; i < got.size(); i++) if (got[i].sop) sops++;
    total++;
    if (proto_err !== 1'b1 || sops != 1) begin
      bad++;
      $display("FAIL proto_midsop: err=%b sops=%0d required=1 1", proto_err, sops);
    end
    check_stream("proto");
  endtask

  task automatic test_single_word();
    do_reset();
    add_packet(0, 1, 3'd3, -1);
    drive();
    run("single", 50);
    total++;
    if (got.size() != 1 || got[0].sop !== 1'b1 || got[0].eop !== 1'b1 || got[0].mod !== 3'd3) begin
      bad++;
      $display("FAIL single_word: words=%0d required=1 with sop=eop=1 mod=3", got.size());
    end
    total++;
    if (busy_hi != 0) begin
      bad++;
      $display("FAIL single_busy: busy_cycles=%0d required=0", busy_hi);
    end
    check_stream("single");
  endtask

  task automatic test_random();
    int len;
    logic exp_trunc;
    do_reset();
    gap_pct = 30;
    full_pct = 25;
    exp_trunc = 1'b0;
    for (int k = 0; k < 24; k++) begin
      len = int'($urandom_range(6, 1));
      if (len > MW) exp_trunc = 1'b1;
      add_packet(int'($urandom_range(1)), len, 3'($urandom_range(7)), -1);
    end
    drive();
    run("random", 3000);
    total++;
    if (trunc_err !== exp_trunc || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL random_flags: trunc=%b proto=%b required=%b 0", trunc_err, proto_err, exp_trunc);
    end
    check_stream("random");
  endtask

  initial begin
    rst_n = 1'b0;
    src_val = '0;
    src_sop = '0;
    src_eop = '0;
    src_mod = '0;
    src_data = '0;
    pkt_tx_full = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_proto_err();
    test_single_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xge_tx_arbiter.md
Name: xge_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single xge_mac transmit packet interface (pkt_tx_*) between NUM_SRC independent packet sources.
- Each packet is granted atomically from sop to eop. Backpressure comes from pkt_tx_full.
- A maximum-length guard truncates runaway packets; protocol errors are flagged as sticky status.
- Sits in the clk_156m25 domain directly in front of the xge_mac pkt_tx port.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- MAX_WORDS, 1200, maximum 64-bit words per packet before forced truncation (≥2).

Ports:
- clk_156m25  in  1  core clock.
- reset_156m25_n  in  1  asynchronous active-low reset.
- src_val  in  NUM_SRC  per-source word valid.
- src_sop  in  NUM_SRC  per-source start of packet.
- src_eop  in  NUM_SRC  per-source end of packet.
- src_mod  in  3*NUM_SRC  per-source valid-byte modulo; source i occupies bits [3i+2:3i].
- src_data  in  64*NUM_SRC  per-source data; source i occupies bits [64i+63:64i].
- src_ready  out  NUM_SRC  per-source word accept. A word transfers when src_val[i] && src_ready[i].
- pkt_tx_full  in  1  MAC TX FIFO full.
- pkt_tx_val  out  1  to MAC.
- pkt_tx_sop  out  1  to MAC.
- pkt_tx_eop  out  1  to MAC.
- pkt_tx_mod  out  3  to MAC.
- pkt_tx_data  out  64  to MAC.
- grant_id  out  clog2(NUM_SRC)  current/last granted source.
- busy  out  1  a packet is in progress (state != IDLE).
- trunc_err  out  1  sticky; packet truncated at MAX_WORDS.
- proto_err  out  1  sticky; missing or misplaced sop seen.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer 0, word counter 0.
- Output path:
  - pkt_tx_* are registered. Latency from source transfer to MAC is exactly 1 cycle.
  - pkt_tx_val=0 in every cycle with no transfer.
  - sop/eop/mod/data in non-valid cycles hold their last value.
- pkt_tx_mod:
  - Equals the source mod when eop is forwarded; 0 otherwise.
  - 0 means all 8 bytes valid.
- Backpressure:
  - src_ready is combinational. It is 0 for all sources while pkt_tx_full=1, except in DRAIN.
  - At most one word reaches the MAC after pkt_tx_full rises; the MAC full threshold provides this slack.
- State IDLE:
  - Candidate set: sources with src_val && src_sop.
  - Selection: the first candidate at or after (RR pointer) modulo NUM_SRC.
  - If a candidate exists and pkt_tx_full=0: accept its sop word, latch grant_id, set counter=1, RR pointer = grant+1 mod NUM_SRC.
  - Next state is XFER, or stays IDLE if sop&&eop (single-word packet).
  - Sources presenting src_val without src_sop while in IDLE: src_ready=1, word dropped, proto_err set. This applies only when the source is not selected and pkt_tx_full=0.
- State XFER:
  - Only the granted source sees src_ready=!pkt_tx_full; all others see 0.
  - Each accepted word is forwarded and the counter increments.
  - eop accepted -> IDLE.
  - src_sop on an accepted mid-packet word: forwarded with sop=0, proto_err set.
  - Truncation: if the accepted word is the MAX_WORDS-th and lacks eop, forward it with eop=1, mod=0, set trunc_err, go to DRAIN.
- State DRAIN:
  - src_ready[grant]=1 regardless of pkt_tx_full.
  - Words are discarded, with no MAC output.
  - eop accepted -> IDLE.
- Back-to-back operation: from XFER eop, the next packet's sop may be accepted the following cycle (1 idle cycle max between packets).
- Simultaneous err_clr and a new error in the same cycle: the set wins.
- Counter width: clog2(MAX_WORDS+1). It never wraps, because truncation fires first.
- busy=1 in XFER and DRAIN.
- Asynchronous reset mid-packet aborts immediately to IDLE. The MAC shares reset_156m25_n, so no partial-packet recovery is required.

Decomposition:
- Shared package xge_tx_arb_pkg holds:
  - the state enum typedef (IDLE, XFER, DRAIN);
  - a word struct typedef {sop, eop, mod[2:0], data[63:0]};
  - localparam widths.
- One sub-module, xge_rr_pick: a combinational round-robin priority picker (request vector + pointer -> one-hot grant + valid).

Test Plan:
- Reset: assert reset_156m25_n=0 mid-packet -> all outputs 0 asynchronously; after release, the first sop from src1 is forwarded with 1-cycle latency.
- Round-robin: src0 and src1 each continuously offer 4-word packets -> MAC sees alternating grant_id 0,1,0,1; each packet is contiguous; mod forwarded only on eop.
- Backpressure: pkt_tx_full=1 for 5 cycles mid-packet -> src_ready=0 for those cycles, at most 1 word in flight, no word lost or duplicated; the data sequence is preserved.
- Truncation: MAX_WORDS=4; src0 sends a 7-word packet -> MAC receives 4 words with eop on the 4th and mod=0; trunc_err=1; 3 words drained; the next src1 packet is forwarded normally.
- Protocol errors:
  - A non-sop word from src1 in IDLE -> dropped, proto_err=1.
  - Mid-packet sop -> forwarded with pkt_tx_sop=0.
  - err_clr asserted -> both flags return to 0.
- Single-word packet: sop&&eop with mod=3 -> one MAC word with sop=eop=1 and mod=3; state remains IDLE; busy stays 0.
